// File: rtl/icache_refill.sv
// icache_refill: icache miss refill engine, burst-reads one line and writes it into the victim way
module icache_refill #(
  parameter int ADDR_WIDTH = 64,
  parameter int BUS_WIDTH  = 32,
  parameter int LINE_BEATS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss,
  input  logic [ADDR_WIDTH-1:0]          miss_addr,
  input  logic                           lru,
  output logic                           ar_valid,
  input  logic                           ar_ready,
  output logic [ADDR_WIDTH-1:0]          ar_addr,
  output logic [7:0]                     ar_len,
  input  logic                           r_valid,
  output logic                           r_ready,
  input  logic [BUS_WIDTH-1:0]           r_data,
  input  logic [1:0]                     r_resp,
  input  logic                           r_last,
  output logic [1:0]                     line_we,
  output logic [ADDR_WIDTH-1:0]          line_addr,
  output logic [LINE_BEATS*BUS_WIDTH-1:0] line_data,
  output logic                           refresh,
  output logic                           busy,
  output logic                           err
);
  localparam int OFS = $clog2(LINE_BEATS*BUS_WIDTH/8);
  localparam int BW  = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MASK = ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));
  typedef enum logic [2:0] {IDLE, REQ, RECV, FILL, FAIL} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_BEATS*BUS_WIDTH-1:0] line_buf;
  logic [BW-1:0] beat_cnt;
  logic way_q, err_q, last, beat_err, accept;
  assign last     = beat_cnt == BW'(LINE_BEATS-1);
  assign beat_err = (r_resp != 2'b00) || (r_last != last);
  assign accept   = state == RECV && r_valid;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = miss ? REQ : IDLE;
      REQ:  state_n = ar_ready ? RECV : REQ;
      RECV: state_n = accept && last ? ((err_q || beat_err) ? FAIL : FILL) : RECV;
      default: state_n = IDLE;
    endcase
  end
  // Beats land in ascending order; beat_cnt alone decides when the line is complete.
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr_q   <= '0;
      way_q    <= 1'b0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
      line_buf <= '0;
    end else if (state == IDLE && miss) begin
      addr_q   <= miss_addr & MASK;
      way_q    <= lru;
      err_q    <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      line_buf[int'(beat_cnt)*BUS_WIDTH +: BUS_WIDTH] <= r_data;
      err_q    <= err_q | beat_err;
      beat_cnt <= beat_cnt + BW'(1);
    end
  assign ar_valid  = state == REQ;
  assign ar_addr   = addr_q;
  assign ar_len    = 8'(LINE_BEATS-1);
  assign r_ready   = state == RECV;
  assign line_we   = {way_q, ~way_q} & {2{state == FILL}};
  assign line_addr = addr_q;
  assign line_data = line_buf;
  assign refresh   = state == FILL;
  assign busy      = state != IDLE;
  assign err       = state == FAIL;
endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-handling refill engine for the instruction cache. It accepts a miss and victim-way indication from the icache tag array and issues a line-aligned burst read on the memory read channel. It assembles the returned beats into one cache line, writes the line into the victim way of the data array, and pulses `refresh` so the tag array installs the new tag and flips LRU. It sits between the icache tag/data arrays and the memory read port of the bus bridge.

## Interface
- `ADDR_WIDTH`, 64, physical address width.
- `BUS_WIDTH`, 32, read-data beat width in bits.
- `LINE_BEATS`, 2, beats per line (power of two, 1..8); line = `LINE_BEATS*BUS_WIDTH` bits, 64 bits by default.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `miss` in 1: tag-array miss, level; sampled only in IDLE.
- `miss_addr` in ADDR_WIDTH: fetch address of the missing access.
- `lru` in 1: victim way for `miss_addr`'s index (0 = way0, 1 = way1).
- `ar_valid` out 1, `ar_ready` in 1: read-address handshake.
- `ar_addr` out ADDR_WIDTH: line-aligned request address.
- `ar_len` out 8: constant `LINE_BEATS-1`.
- `r_valid` in 1, `r_ready` out 1: read-data handshake.
- `r_data` in BUS_WIDTH, `r_resp` in 2, `r_last` in 1: beat payload, response code, last-beat flag.
- `line_we` out 2: one-hot data-array write enable, bit = victim way.
- `line_addr` out ADDR_WIDTH: line-aligned address for the data-array write.
- `line_data` out LINE_BEATS*BUS_WIDTH: assembled line.
- `refresh` out 1: one-cycle pulse to tag array; installs tag and toggles LRU.
- `busy` out 1: high whenever state ≠ IDLE; used as icache stall request.
- `err` out 1: one-cycle pulse on failed refill.

## Operation
- **States:** IDLE, REQ, RECV, FILL, FAIL.
- **IDLE:**
  - If `miss`=1, latch `addr_q = miss_addr` with the low log2(LINE_BEATS*BUS_WIDTH/8) bits cleared.
  - Latch `way_q = lru`, clear `beat_cnt` and `err_q`, then go to REQ.
- **REQ:**
  - `ar_valid`=1 and `ar_addr`=`addr_q`.
  - Both are held stable until `ar_ready`; on `ar_valid & ar_ready`, go to RECV.
- **RECV:**
  - `r_ready`=1. Each `r_valid` cycle is one accepted beat.
  - The beat is written to `line_buf[beat_cnt*BUS_WIDTH +: BUS_WIDTH]`; beats fill in ascending address order, no critical-word-first.
  - `r_resp`≠0 on any beat sets `err_q`.
  - `r_last` disagreeing with (`beat_cnt == LINE_BEATS-1`) also sets `err_q`. `beat_cnt` is authoritative for termination.
  - On the accepted beat with `beat_cnt == LINE_BEATS-1`, go to FILL if `err_q` is clear (including this beat's contribution), else go to FAIL.
- **FILL:** one cycle; `line_we[way_q]`=1, `refresh`=1, then IDLE.
- **FAIL:** one cycle; `err`=1, no `line_we`, no `refresh`, then IDLE. The tag array re-misses and a new refill starts.
- **Output sources:** `line_addr` = `addr_q`; `line_data` = `line_buf` (registered). `ar_len` is constant.
- **Miss while not IDLE:** `miss` and `miss_addr` changes are ignored; exactly one outstanding request.

## Timing
- **Reset values:**
  - Outputs: `ar_valid`, `r_ready`, `line_we`, `refresh`, `busy`, `err` = 0; `ar_addr`, `line_addr`, `line_data` = 0.
  - Internal: state = IDLE, `beat_cnt` = 0.
- **Reset mid-transaction:** the transaction is abandoned immediately and no `refresh` is issued. The bus bridge is reset by the same `rst_n`.
- **Minimum latency, miss to refresh:** 2 + LINE_BEATS cycles (4 by default).
  - Miss seen in IDLE at cycle 0; `ar_valid` in cycle 1.
  - With `ar_ready`=1 in cycle 1, beats arrive in cycles 2..1+LINE_BEATS.
  - `refresh` is high in cycle 2+LINE_BEATS.
- **Back-to-back misses:** the cycle after FILL is IDLE. The tag array has updated at the FILL edge, so a stale miss for the same line is not re-sampled. A different missing address is accepted in that IDLE cycle.
- **`busy`:** rises the cycle after `miss` is sampled; falls the cycle after FILL/FAIL.
- **Stalls:** `r_valid`=0 gaps in RECV stall without state change. `ar_ready` may be low for any number of cycles.

## Test plan
- Reset, then `miss`=1, `miss_addr`=0x8000_0014, `lru`=1, zero-wait memory returning 0x1111_1111 then 0x2222_2222 → `ar_addr`=0x8000_0010, `ar_len`=1, `refresh` and `line_we`=2'b10 in cycle 4, `line_data`=0x2222_2222_1111_1111.
- `ar_ready` low for 5 cycles, `r_valid` with one bubble between beats → `ar_addr` stable throughout, `refresh` in cycle 10, data correct.
- Second beat with `r_resp`=2'b10 → `err` pulses once, `line_we`=0, `refresh`=0, `busy` falls, next `miss` restarts at REQ.
- `r_last`=1 on the first of two beats → FAIL path taken after the second beat, `err`=1, no write.
- `rst_n`=0 asserted during RECV after one beat → next cycle all outputs 0, state IDLE; a subsequent miss completes normally.
- Miss toggling to a new address while in RECV → ignored; refill completes for the original line with `line_addr` unchanged.
